// File: rtl/alu_serial_adder_seq.sv
// ============================================================================
// alu_serial_adder_seq
//
// Multi-cycle add/subtract sequencer built around a 2-bit full-adder slice.
// A WIDTH-bit request is accepted over a valid/ready handshake. The operands
// are consumed two bits per cycle, least-significant pair first, with the
// carry chained between cycles. Sum pairs are shifted into the result
// register from the top. Result and flags are then presented over a second
// valid/ready handshake.
//
// Optional feature macro: ALU_SERIAL_FLAGS_EN
//   defined   : overflow and zero are registered and valid in DONE. zero is
//               built from a running OR of the sum pairs.
//   undefined : overflow and zero are tied to 0. result and carry_out are
//               unchanged.
//
// Parameters
//   WIDTH      operand/result width, must be even and >= 4 (default 32)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   sequencer idle and able to accept a request
//   a, b       operands, sampled on the input handshake
//   sub        1 = a - b, 0 = a + b, sampled on the input handshake
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   result     sum/difference modulo 2^WIDTH
//   carry_out  carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   overflow   signed overflow (flags build only)
//   zero       result == 0 (flags build only)
// ============================================================================
module alu_serial_adder_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             out_valid_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic             ovf_q;
    logic             zero_q;
    logic             zacc_q;
`endif

    // 2-bit slice: c1_d is the carry between the two bit positions, which on
    // the final step is the carry into the MSB.
    logic             s0_d;
    logic             s1_d;
    logic             c1_d;
    logic             c2_d;
    logic             last_step;

    always_comb begin
        s0_d = a_q[0] ^ b_q[0] ^ carry_q;
        c1_d = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        s1_d = a_q[1] ^ b_q[1] ^ c1_d;
        c2_d = (a_q[1] & b_q[1]) | (c1_d & (a_q[1] ^ b_q[1]));
    end

    assign last_step = (cnt_q == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            zacc_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract as a + ~b + 1: invert b here, inject the +1
                        // as the initial carry.
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
`ifdef ALU_SERIAL_FLAGS_EN
                        zacc_q  <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> 2;
                    b_q     <= b_q >> 2;
                    carry_q <= c2_d;
                    res_q   <= {s1_d, s0_d, res_q[WIDTH-1:2]};
                    // Terminal count wraps to 0 on the way into DONE.
                    cnt_q   <= cnt_q + CW'(1);
`ifdef ALU_SERIAL_FLAGS_EN
                    zacc_q  <= zacc_q | s0_d | s1_d;
`endif
                    if (last_step) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
`ifdef ALU_SERIAL_FLAGS_EN
                        ovf_q       <= c1_d ^ c2_d;
                        zero_q      <= ~(zacc_q | s0_d | s1_d);
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign carry_out = carry_q;

`ifdef ALU_SERIAL_FLAGS_EN
    assign overflow  = ovf_q;
    assign zero      = zero_q;
`else
    assign overflow  = 1'b0;
    assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_adder_seq.sv
// ============================================================================
// tb_alu_serial_adder_seq
//
// Directed testbench for alu_serial_adder_seq (WIDTH = 32). Expected values
// are hand-computed; zero/overflow expectations follow ALU_SERIAL_FLAGS_EN.
// ============================================================================
module tb_alu_serial_adder_seq;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int n_chk = 0;
    int n_bad = 0;

    alu_serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present a request at the negedge; the handshake happens on the next
    // posedge. Returns #1 after that edge.
    task automatic start_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic sv);
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        sub      = sv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    // Count edges from the handshake until out_valid; bounded.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk({tag, ".latency"}, 32'(lat), 32'd16);
    endtask

    task automatic chk_res(input string tag, input logic [31:0] r, input logic c,
                           input logic v, input logic z);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"},    result,         r);
        chk({tag, ".carry"},     32'(carry_out), 32'(c));
`ifdef ALU_SERIAL_FLAGS_EN
        chk({tag, ".overflow"},  32'(overflow),  32'(v));
        chk({tag, ".zero"},      32'(zero),      32'(z));
`else
        chk({tag, ".overflow"},  32'(overflow),  32'd0);
        chk({tag, ".zero"},      32'(zero),      32'd0);
        if (v || z) begin end
`endif
    endtask

    // With out_ready high, out_valid must drop after one cycle.
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    task automatic full_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic sv, input logic [31:0] r, input logic c,
                           input logic v, input logic z);
        out_ready = 1'b1;
        start_op(tag, av, bv, sv);
        wait_done(tag);
        chk_res(tag, r, c, v, z);
        release_out(tag);
    endtask

    initial begin
        int viol;
        logic [31:0] r0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result",    result,         32'd0);
        chk("rst.carry",     32'(carry_out), 32'd0);
        chk("rst.overflow",  32'(overflow),  32'd0);
        chk("rst.zero",      32'(zero),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        full_op("add3p5",   32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        full_op("addwrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        full_op("addovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        full_op("sub5m7",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        full_op("subeq",    32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: hold DONE for 10 cycles while a new request waits.
        out_ready = 1'b0;
        start_op("bp", 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        wait_done("bp");
        chk_res("bp", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        r0       = result;
        in_valid = 1'b1;
        a        = 32'h8000_0000;
        b        = 32'h8000_0000;
        sub      = 1'b0;
        viol     = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || result !== r0 || in_ready !== 1'b0) viol++;
        end
        chk("bp.hold", 32'(viol), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.released",  32'(out_valid), 32'd0);
        chk("bp.idle",      32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp2.in_ready_low", 32'(in_ready), 32'd0);
        wait_done("bp2");
        chk_res("bp2", 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        release_out("bp2");

        // Reset mid-RUN: outputs must clear without a clock edge.
        out_ready = 1'b1;
        start_op("rstrun", 32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstrun.in_ready",  32'(in_ready),  32'd1);
        chk("rstrun.out_valid", 32'(out_valid), 32'd0);
        chk("rstrun.result",    result,         32'd0);
        chk("rstrun.carry",     32'(carry_out), 32'd0);
        chk("rstrun.overflow",  32'(overflow),  32'd0);
        chk("rstrun.zero",      32'(zero),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        viol  = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) viol++;
        end
        chk("rstrun.no_result", 32'(viol), 32'd0);
        full_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_adder_seq.md
# alu_serial_adder_seq

Multi-cycle sequencer around the 2-bit adder slice. It accepts a WIDTH-bit add/subtract request over a valid/ready handshake and feeds the operands through a 2-bit full-adder datapath, least-significant pair first, chaining the carry between cycles. It assembles the result into a shift register and presents result and flags to the downstream writeback consumer over a second valid/ready handshake. This is the area-minimal ALU adder path for the small-core configuration.

## Interface
- WIDTH, 32, operand/result width; must be even and ≥ 4
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  sequencer can accept a request
- a  input  WIDTH  operand A, sampled on input handshake
- b  input  WIDTH  operand B, sampled on input handshake
- sub  input  1  1 = A − B, 0 = A + B, sampled on input handshake
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference modulo 2^WIDTH
- carry_out  output  1  carry from bit WIDTH−1 (for subtract: 1 = no borrow)
- overflow  output  1  signed overflow (see Configuration)
- zero  output  1  result == 0 (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b^{WIDTH{sub}}, carry=sub, step counter=0, go to RUN.
- RUN: in_ready=0. Each cycle, add operand bits [1:0] plus the carry through the 2-bit slice. Shift the 2 sum bits into result from the top. Shift operands right 2. Update carry. Increment the counter.
  - After step WIDTH/2−1, go to DONE.
  - Before the last step, record carry into bit WIDTH−1 for overflow.
- DONE: out_valid=1; result and flags stable. On out_ready, go to IDLE. A new request may be accepted no earlier than the cycle after that.
- in_ready is combinational from state only. There is no dependency on out_ready and no back-to-back overlap.
- Arithmetic:
  - result = (a + (sub ? ~b : b) + sub) mod 2^WIDTH
  - carry_out = bit WIDTH of that sum
  - overflow = carry into MSB XOR carry out of MSB
- in_valid, a, b, sub are ignored outside IDLE.
- out_ready is ignored outside DONE.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0, carry_out=0, overflow=0, zero=0. The counter, operand and carry registers are all 0.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded immediately (asynchronously) and all outputs take their reset values. No result is produced.
- Latency: input handshake at edge N. RUN occupies edges N+1..N+WIDTH/2. out_valid is high after edge N+WIDTH/2 (16 cycles for WIDTH=32).
- out_valid held with stable result until the handshake. With out_ready held high, out_valid is high for exactly 1 cycle.
- Throughput: at most one operation per WIDTH/2+2 cycles.
- Counter width is clog2(WIDTH/2). The terminal count wraps to 0 on the transition to DONE.

## Configuration
- ALU_SERIAL_FLAGS_EN defined:
  - overflow and zero are registered and valid in DONE.
  - zero is computed by a running OR of sum pairs during RUN, not by a final wide compare.
- ALU_SERIAL_FLAGS_EN undefined:
  - overflow and zero are tied to 0.
  - The MSB-carry capture and zero accumulator are not built.
  - result and carry_out are unaffected.

## Test plan
- Reset, then a=3, b=5, sub=0, out_ready=1, WIDTH=32 -> in_ready falls the cycle after the handshake. out_valid rises exactly 16 cycles after the handshake with result=8, carry_out=0, zero=0, overflow=0.
- a=0xFFFFFFFF, b=1, sub=0 -> result=0, carry_out=1, zero=1 (flags build), overflow=0.
- a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, overflow=1, carry_out=0. Then a=5, b=7, sub=1 -> result=0xFFFFFFFE, carry_out=0 (borrow), overflow=0.
- out_ready held 0 for 10 cycles in DONE while in_valid=1 with new operands -> out_valid stays 1, result unchanged, in_ready stays 0. After out_ready=1 for one cycle, the next request is accepted in IDLE and produces a correct result.
- rst_n pulsed low at RUN step 7 of a=0x12345678, b=0x11111111 -> outputs go to reset values immediately. No out_valid follows. A subsequent request completes normally (result 0x23456789).
- Build without ALU_SERIAL_FLAGS_EN and repeat scenario 2 -> result=0, carry_out=1, zero=0, overflow=0.
